// File: rtl/multicycle_cla_adder.sv
// Multicycle adder: one 4-bit carry-lookahead slice per cycle, LSB slice first.
// Define SIGNED_OVF_EN to add the registered two's-complement overflow output ovf_out.
module multicycle_cla_adder #(
    parameter int NUMBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic               c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] s_out,
    output logic               c_out,
`ifdef SIGNED_OVF_EN
    output logic               ovf_out,
`endif
    output logic               busy
);

    localparam int NUMSLICES = NUMBITS / 4;
    localparam int KW = (NUMSLICES > 1) ? $clog2(NUMSLICES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NUMSLICES - 1);

    generate
        if (NUMBITS < 4 || (NUMBITS % 4) != 0) begin : g_bad_width
            $error("multicycle_cla_adder: NUMBITS must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Returns {carry_out, sum[3:0]} from lookahead generate/propagate terms.
    function automatic logic [4:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       ci
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    state_t             state_q, state_d;
    logic [NUMBITS-1:0] a_q, a_d;
    logic [NUMBITS-1:0] b_q, b_d;
    logic [NUMBITS-1:0] sum_q, sum_d;
    logic [NUMBITS-1:0] s_q, s_d;
    logic               carry_q, carry_d;
    logic               c_q, c_d;
    logic [KW-1:0]      k_q, k_d;
`ifdef SIGNED_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [KW+1:0] base;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    slice_s;
    logic          slice_co;

    assign base  = {k_q, 2'b00};
    assign a_nib = a_q[base +: 4];
    assign b_nib = b_q[base +: 4];
    assign {slice_co, slice_s} = cla4(a_nib, b_nib, carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_d     = c_q;
        k_d     = k_q;
`ifdef SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = c_in;
                    sum_d   = '0;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[base +: 4] = slice_s;
                carry_d          = slice_co;
                k_d              = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    // Publish only the complete result; partial sums stay internal.
                    s_d     = sum_d;
                    c_d     = slice_co;
                    k_d     = '0;
                    state_d = DONE;
`ifdef SIGNED_OVF_EN
                    ovf_d   = slice_s[3] ^ a_nib[3] ^ b_nib[3] ^ slice_co;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            k_q     <= '0;
`ifdef SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            k_q     <= k_d;
`ifdef SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s_out     = s_q;
    assign c_out     = c_q;
`ifdef SIGNED_OVF_EN
    assign ovf_out   = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_cla_adder.sv
// Directed bench for multicycle_cla_adder: 16-bit instance plus a 4-bit
// instance swept exhaustively.
module tb_multicycle_cla_adder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
    logic [15:0] a_in, b_in, s_out;
    logic        in_valid4, in_ready4, c_in4, out_valid4, out_ready4, c_out4, busy4;
    logic [3:0]  a_in4, b_in4, s_out4;
`ifdef SIGNED_OVF_EN
    logic        ovf16, ovf4;
`endif

    int total = 0;
    int bad   = 0;

    multicycle_cla_adder #(.NUMBITS(16)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s_out    (s_out),
        .c_out    (c_out),
`ifdef SIGNED_OVF_EN
        .ovf_out  (ovf16),
`endif
        .busy     (busy)
    );

    multicycle_cla_adder #(.NUMBITS(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid4),
        .in_ready (in_ready4),
        .a_in     (a_in4),
        .b_in     (b_in4),
        .c_in     (c_in4),
        .out_valid(out_valid4),
        .out_ready(out_ready4),
        .s_out    (s_out4),
        .c_out    (c_out4),
`ifdef SIGNED_OVF_EN
        .ovf_out  (ovf4),
`endif
        .busy     (busy4)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation on dut16 with out_ready high; edges counts the
    // capture edge as edge 1 up to the edge that raises out_valid.
    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic c, output logic [16:0] res,
                         output int edges);
        @(negedge clk);
        a_in      = a;
        b_in      = b;
        c_in      = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        res = {c_out, s_out};
    endtask

    logic [16:0] res;
    int          edges;
    int          n;
    logic        seen;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        c_in       = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        a_in4      = '0;
        b_in4      = '0;
        c_in4      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s_out", s_out, 0);
        check("rst_c_out", c_out, 0);
        check("rst_busy", busy, 0);

        run16(16'h1234, 16'h4321, 1'b0, res, edges);
        check("add_1234_4321", res, 17'h0_5555);
        check("latency_edges", edges, 5);
        @(negedge clk);
        check("valid_one_cycle", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_hold_s", s_out, 16'h5555);

        run16(16'hFFFF, 16'h0000, 1'b1, res, edges);
        check("ripple_all", res, 17'h1_0000);
`ifdef SIGNED_OVF_EN
        check("ovf_ffff", ovf16, 0);
`endif
        @(negedge clk);

`ifdef SIGNED_OVF_EN
        run16(16'h7FFF, 16'h0001, 1'b0, res, edges);
        check("ovf_sum", res, 17'h0_8000);
        check("ovf_flag", ovf16, 1);
        @(negedge clk);
`endif

        // Stall the result channel and offer a pair that must be ignored.
        @(negedge clk);
        a_in      = 16'h0F0F;
        b_in      = 16'h0101;
        c_in      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", out_valid, 1);
        check("stall_sum", {c_out, s_out}, 17'h0_1010);
        a_in     = 16'h1111;
        b_in     = 16'h2222;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_s", s_out, 16'h1010);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        a_in      = 16'h0003;
        b_in      = 16'h0004;
        @(negedge clk);
        check("release_idle", in_ready, 1);
        check("release_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("second_busy", busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("second_sum", {c_out, s_out}, 17'h0_0007);
        @(negedge clk);

        // Abort in the second CALC cycle.
        @(negedge clk);
        a_in     = 16'hAAAA;
        b_in     = 16'h5555;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_s_out", s_out, 0);
        check("abort_c_out", c_out, 0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("abort_no_valid", seen, 0);

        // Exhaustive 4-bit sweep with back-to-back handshakes.
        out_ready4 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a_in4     = 4'(a);
                    b_in4     = 4'(b);
                    c_in4     = 1'(c);
                    in_valid4 = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    in_valid4 = 1'b0;
                    n = 0;
                    while (!out_valid4 && n < 10) begin
                        @(negedge clk);
                        n++;
                    end
                    if (a == 0 && b == 0 && c == 0)
                        check("lat4_edges", n + 1, 2);
                    check("sweep4", {c_out4, s_out4}, a + b + c);
                    $display("op a=%0d b=%0d c=%0d -> %0d", a, b, c,
                             {c_out4, s_out4});
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
